// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - tick-driven LED pattern sequencer with mode/speed/pause buttons
module led_pattern_ctrl #(
    parameter int LED_W    = 4,
    parameter int BASE_DIV = 12_500_000,
    parameter int CNT_W    = $clog2(4*BASE_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode_btn,
    input  logic             speed_btn,
    input  logic             pause_btn,
    output logic [LED_W-1:0] led,
    output logic [2:0]       mode,
    output logic [1:0]       speed,
    output logic             paused,
    output logic             tick
);

    localparam logic [2:0] MODE_ROT_R  = 3'd0;
    localparam logic [2:0] MODE_ROT_L  = 3'd1;
    localparam logic [2:0] MODE_BOUNCE = 3'd2;
    localparam logic [2:0] MODE_BLINK  = 3'd3;
    localparam logic [2:0] MODE_FILL   = 3'd4;

    localparam logic [LED_W-1:0] LED_ONE  = LED_W'(1);
    localparam logic [LED_W-1:0] LED_ALL  = {LED_W{1'b1}};
    localparam logic [LED_W-1:0] LED_NONE = '0;

    typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;

    logic [LED_W-1:0] led_q, led_d;
    logic [2:0]       mode_q, mode_d;
    logic [1:0]       speed_q, speed_d;
    logic             paused_q, paused_d;
    logic             tick_q, tick_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             dir_q, dir_d;

    logic [CNT_W-1:0] period_m1;
    logic [2:0]       mode_next;
    logic [LED_W-1:0] led_shl, led_shr;
    logic             run;

    function automatic logic [LED_W-1:0] init_pattern(input logic [2:0] m);
        case (m)
            MODE_BLINK: init_pattern = LED_ALL;
            MODE_FILL:  init_pattern = LED_NONE;
            default:    init_pattern = LED_ONE;
        endcase
    endfunction

    always_comb begin
        case (speed_q)
            2'd0: period_m1 = CNT_W'(BASE_DIV - 1);
            2'd1: period_m1 = CNT_W'(2*BASE_DIV - 1);
            2'd2: period_m1 = CNT_W'(3*BASE_DIV - 1);
            2'd3: period_m1 = CNT_W'(4*BASE_DIV - 1);
        endcase
    end

    assign mode_next = (mode_q >= MODE_FILL) ? MODE_ROT_R : mode_q + 3'd1;
    assign led_shl   = {led_q[LED_W-2:0], 1'b0};
    assign led_shr   = {1'b0, led_q[LED_W-1:1]};
    // Mode/speed presses reset the divider, so they preempt any tick that edge.
    assign run       = !paused_q && !mode_btn && !speed_btn;

    always_comb begin
        led_d    = led_q;
        mode_d   = mode_q;
        speed_d  = speed_q;
        paused_d = paused_q;
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        tick_d   = 1'b0;

        if (run) begin
            if (cnt_q != period_m1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!pause_btn) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                case (mode_q)
                    MODE_ROT_R: led_d = {led_q[0], led_q[LED_W-1:1]};
                    MODE_ROT_L: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
                    MODE_BOUNCE: begin
                        if (dir_q == DIR_LEFT) begin
                            led_d = led_shl;
                            if (led_shl[LED_W-1]) dir_d = DIR_RIGHT;
                        end else begin
                            led_d = led_shr;
                            if (led_shr[0]) dir_d = DIR_LEFT;
                        end
                    end
                    MODE_BLINK: led_d = ~led_q;
                    MODE_FILL:  led_d = (led_q == LED_ALL) ? LED_NONE
                                                           : {led_q[LED_W-2:0], 1'b1};
                    default: begin
                        mode_d = MODE_ROT_R;
                        led_d  = LED_ONE;
                        dir_d  = DIR_LEFT;
                    end
                endcase
            end
        end

        if (pause_btn) paused_d = !paused_q;
        if (mode_btn) begin
            mode_d = mode_next;
            led_d  = init_pattern(mode_next);
            dir_d  = DIR_LEFT;
            cnt_d  = '0;
        end
        if (speed_btn) begin
            speed_d = speed_q + 2'd1;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q    <= LED_ONE;
            mode_q   <= MODE_ROT_R;
            speed_q  <= 2'd0;
            paused_q <= 1'b0;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
            dir_q    <= DIR_LEFT;
        end else begin
            led_q    <= led_d;
            mode_q   <= mode_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
            tick_q   <= tick_d;
            cnt_q    <= cnt_d;
            dir_q    <= dir_d;
        end
    end

    assign led    = led_q;
    assign mode   = mode_q;
    assign speed  = speed_q;
    assign paused = paused_q;
    assign tick   = tick_q;

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Sequencer for the board LED bank. It holds a divider-based tick generator and steps a selectable LED pattern on each tick. Three debounced, single-cycle button pulses control it: mode select, speed select and pause/resume. It replaces the fixed free-running rotator and sits between the button conditioning logic and the LED pins.

Parameters:
LED_W, 4, number of LEDs driven (must be >= 2)
BASE_DIV, 12_500_000, clock cycles per tick at speed 0 (0.25 s at 50 MHz); must be >= 2
CNT_W, $clog2(4*BASE_DIV), divider counter width

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
mode_btn  in  1  one-cycle pulse; advance to next pattern mode
speed_btn  in  1  one-cycle pulse; advance to next speed level
pause_btn  in  1  one-cycle pulse; toggle paused state
led  out  LED_W  registered LED drive, 1 = on
mode  out  3  current mode code
speed  out  2  current speed level
paused  out  1  1 = sequencing frozen
tick  out  1  registered one-cycle pulse, coincident with each led step

Behaviour:
- Reset (rst_n=0 at posedge clk) has top priority and gives:
  - mode=0, speed=0, paused=0, led=0...01, tick=0.
  - Divider cnt=0; bounce direction=LEFT.
- Tick period P = BASE_DIV*(speed+1), so 1x to 4x BASE_DIV.
- Divider counts 0..P-1. At a posedge with cnt==P-1, paused=0 and no mode_btn/speed_btn, all of the following happen on the same edge:
  - cnt<=0, tick<=1, led<=next(led).
  - The new led value and tick are therefore visible in the same cycle.
  - Otherwise tick<=0.
- Paused=1:
  - cnt, led and direction hold; tick=0.
  - On resume, counting continues from the held cnt. There is no restart.
- Modes (mode_btn cycles 0->1->2->3->4->0). Init value is loaded on entry. Sequences below are for LED_W=4:
  - 0 ROT_R: init 0001; next={led[0],led[W-1:1]}; 0001,1000,0100,0010,0001.
  - 1 ROT_L: init 0001; next={led[W-2:0],led[W-1]}; 0001,0010,0100,1000,0001.
  - 2 BOUNCE: init 0001, dir=LEFT. Shift in dir. When the shifted-in result hits the end bit (MSB for LEFT, LSB for RIGHT), dir flips on the same edge. Sequence 0001,0010,0100,1000,0100,0010,0001,0010... (period 2W-2).
  - 3 BLINK: init all-ones; next=~led; 1111,0000,1111.
  - 4 FILL: init 0...0; next=(led==all-ones)?0:{led[W-2:0],1'b1}; 0000,0001,0011,0111,1111,0000.
  - Codes 5..7 are unreachable. If present, the next tick forces mode=0 and led=0...01.
- mode_btn:
  - mode<=next mode; led<=init of new mode; cnt<=0; dir<=LEFT; tick=0 that cycle.
  - Applies even while paused; the led shows the init pattern and stays paused.
- speed_btn:
  - speed<=speed+1, wrapping 3->0; cnt<=0; led unchanged; tick=0 that cycle.
- Simultaneous events:
  - mode_btn+speed_btn: both apply; cnt<=0; led=new mode init.
  - Any button on the cycle cnt==P-1: the button wins, no tick, no led step.
  - pause_btn together with others: paused toggles and the other actions still apply.
- mode, speed and paused are direct register outputs. There is no combinational path from inputs to outputs.

Test Plan:
- BASE_DIV=4, release reset: led=0001, mode=0. tick pulses every 4 cycles; led steps 1000,0100,0010,0001, changing in the same cycle tick=1.
- One speed_btn: tick spacing becomes 8 cycles and led is unchanged at the press. Three more presses: speed wraps to 0 and spacing returns to 4.
- mode_btn x2 into BOUNCE: led=0001 immediately, then 0010,0100,1000,0100,0010,0001,0010 on successive ticks. Two more presses into FILL: 0000,0001,0011,0111,1111,0000. A fifth press returns to mode 0 with led=0001.
- pause_btn 2 cycles before a tick: paused=1, led and cnt frozen for 20 cycles, no tick. pause_btn again: the first tick arrives exactly 2 cycles later.
- mode_btn+speed_btn in the same cycle as cnt==P-1: no tick, led=new init, speed incremented, next tick after the full new P.
- Assert rst_n=0 mid-BOUNCE while dir=RIGHT and paused: all outputs return to reset values next edge. After release, ROT_R resumes from 0001 with dir=LEFT.
